// File: rtl/rr_grant_dispatcher.sv
// Requester-side companion of a round-robin arbiter: raises requests, accepts a legal
// one-hot grant, then forwards the winning port's packet onto one egress bus until its last beat.
module rr_grant_dispatcher #(
   parameter int N_REQ  = 16,
   parameter int DATA_W = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [N_REQ-1:0]          i_port_valid,
   input  logic [N_REQ*DATA_W-1:0]   i_port_data,
   input  logic [N_REQ-1:0]          i_port_last,
   output logic [N_REQ-1:0]          o_port_ready,
   output logic [N_REQ-1:0]          o_req,
   input  logic [N_REQ-1:0]          i_grant,
   output logic                      o_valid,
   output logic [DATA_W-1:0]         o_data,
   output logic                      o_last,
   input  logic                      i_ready,
   output logic                      o_busy,
   output logic                      o_grant_err
);

   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE_V  = N_REQ'(1);
   localparam logic [N_REQ-1:0] ZERO_V = {N_REQ{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t             r_state;
   logic [SEL_W-1:0]   r_sel;
   logic [N_REQ-1:0]   r_req;
   logic               r_busy;
   logic               r_grant_err;

   state_t             w_state_nxt;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [N_REQ-1:0]   w_req_nxt;
   logic               w_grant_err_nxt;
   logic               w_onehot;
   logic               w_legal;
   logic [DATA_W-1:0]  w_sel_data;
   logic               w_accept_last;

   // Index of a one-hot vector; OR-combining is exact because at most one bit is set.
   function automatic logic [SEL_W-1:0] f_onehot_idx(input logic [N_REQ-1:0] vec);
      logic [SEL_W-1:0] idx;
      idx = {SEL_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         idx = idx | (vec[k] ? SEL_W'(k) : {SEL_W{1'b0}});
      end
      return idx;
   endfunction

   assign w_onehot   = (i_grant != ZERO_V) && ((i_grant & (i_grant - ONE_V)) == ZERO_V);
   assign w_legal    = w_onehot && ((i_grant & r_req) != ZERO_V);
   assign w_sel_data = i_port_data[r_sel*DATA_W +: DATA_W];

   // Egress pass-through from the locked port; everything is quiet outside XFER.
   always_comb begin
      o_valid      = 1'b0;
      o_data       = {DATA_W{1'b0}};
      o_last       = 1'b0;
      o_port_ready = ZERO_V;
      if (r_state == S_XFER) begin
         o_valid             = i_port_valid[r_sel];
         o_data              = w_sel_data;
         o_last              = i_port_last[r_sel];
         o_port_ready[r_sel] = i_ready;
      end else begin
         o_valid = 1'b0;
      end
   end

   assign w_accept_last = o_valid && i_ready && o_last;

   // Next-state, next request vector, selected port and grant-error decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_sel_nxt       = r_sel;
      w_req_nxt       = ZERO_V;
      w_grant_err_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_nxt = i_port_valid;
            if (i_port_valid != ZERO_V) begin
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ: begin
            w_req_nxt = i_port_valid;
            if (w_legal) begin
               w_sel_nxt   = f_onehot_idx(i_grant);
               w_req_nxt   = ZERO_V;
               w_state_nxt = S_XFER;
            end else if (i_grant != ZERO_V) begin
               w_grant_err_nxt = 1'b1;
               w_state_nxt     = S_REQ;
            end else if (i_port_valid == ZERO_V) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_XFER: begin
            if (w_accept_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_XFER;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = {SEL_W{1'b0}};
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_sel       <= {SEL_W{1'b0}};
         r_req       <= ZERO_V;
         r_busy      <= 1'b0;
         r_grant_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sel       <= w_sel_nxt;
         r_req       <= w_req_nxt;
         r_busy      <= (w_state_nxt == S_XFER);
         r_grant_err <= w_grant_err_nxt;
      end
   end

   assign o_req       = r_req;
   assign o_busy      = r_busy;
   assign o_grant_err = r_grant_err;

endmodule
